// File: rtl/isqrt_reduce_pkg.sv
// Shared types and elaboration helpers for the isqrt sum/max reducer.
package isqrt_reduce_pkg;

   typedef enum logic {
      MODE_SUM = 1'b0,
      MODE_MAX = 1'b1
   } reduce_mode_t;

   // Cycles from the arg_vld sample edge to res_vld.
   function automatic int unsigned isqrt_reduce_latency(input int unsigned w, input int unsigned n_args);
      return w / 2 + $clog2(n_args) + 1;
   endfunction

   // Number of live elements at tree level l when starting from n operands.
   function automatic int unsigned level_count(input int unsigned n, input int unsigned l);
      int unsigned c;
      c = n;
      for (int unsigned i = 0; i < l; i++) c = (c + 1) / 2;
      return c;
   endfunction

endpackage

// File: rtl/isqrt_pipe.sv
// Pipelined restoring integer square root: one root bit per registered stage.
module isqrt_pipe
   import isqrt_reduce_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           x_vld,
   input  logic [W-1:0]   x,
   output logic           y_vld,
   output logic [W/2-1:0] y
);

   localparam int unsigned H   = W / 2;
   localparam int unsigned RMW = H + 2;

   logic [H:0]            vs;
   logic [H:0][W-1:0]     xs;
   logic [H:0][RMW-1:0]   rs;
   logic [H:0][H-1:0]     qs;

   assign vs[0] = x_vld;
   assign xs[0] = x;
   assign rs[0] = '0;
   assign qs[0] = '0;

   for (genvar s = 0; s < H; s++) begin : g_stage
      logic [RMW-1:0] rem_sh;
      logic [RMW-1:0] trial;
      logic [RMW-1:0] rem_d;
      logic [H-1:0]   root_d;
      logic           fits;
      logic           v_r;
      logic [W-1:0]   x_r;
      logic [RMW-1:0] r_r;
      logic [H-1:0]   q_r;

      // Bring down the next two operand bits; remainder stays below 2^(s+2).
      assign rem_sh = RMW'({rs[s], xs[s][W-1 -: 2]});
      assign trial  = RMW'({qs[s], 2'b01});
      assign fits   = (rem_sh >= trial);
      assign rem_d  = fits ? (rem_sh - trial) : rem_sh;
      assign root_d = H'({qs[s], fits});

      always_ff @(posedge clk) begin
         if (!rst) v_r <= 1'b0;
         else      v_r <= vs[s];
      end

      always_ff @(posedge clk) begin
         if (vs[s]) begin
            x_r <= {xs[s][W-3:0], 2'b00};
            r_r <= rem_d;
            q_r <= root_d;
         end
      end

      assign vs[s+1] = v_r;
      assign xs[s+1] = x_r;
      assign rs[s+1] = r_r;
      assign qs[s+1] = q_r;
   end

   assign y_vld = vs[H];
   assign y     = qs[H];

   logic unused_tail;
   assign unused_tail = ^{xs[H], rs[H]};

endmodule

// File: rtl/isqrt_reduce_pipe.sv
// N-channel isqrt followed by a pipelined sum/max reduction tree.
// ISQRT_REDUCE_PIPE_XMASK_EN: drive res to all-x while res_vld is low.
module isqrt_reduce_pipe
   import isqrt_reduce_pkg::*;
#(
   parameter  int unsigned N_ARGS = 3,
   parameter  int unsigned W      = 32,
   localparam int unsigned RW     = W / 2 + $clog2(N_ARGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                arg_vld,
   input  logic                mode,
   input  logic [N_ARGS*W-1:0] args,
   output logic                res_vld,
   output logic [RW-1:0]       res
);

   localparam int unsigned H  = W / 2;
   localparam int unsigned NL = $clog2(N_ARGS);

   logic [N_ARGS-1:0][H-1:0] roots;
   logic [N_ARGS-1:0]        root_vld;

   for (genvar k = 0; k < N_ARGS; k++) begin : g_ch
      isqrt_pipe #(.W(W)) u_isqrt (
         .clk   (clk),
         .rst   (rst),
         .x_vld (arg_vld),
         .x     (args[k*W +: W]),
         .y_vld (root_vld[k]),
         .y     (roots[k])
      );
   end

   // Valid/mode companion chain for the isqrt stages.
   logic [H-1:0] a_vld;
   logic [H-1:0] a_mode;

   always_ff @(posedge clk) begin
      if (!rst) a_vld <= '0;
      else      a_vld <= {a_vld[H-2:0], arg_vld};
   end

   always_ff @(posedge clk) begin
      if (arg_vld) a_mode[0] <= mode;
      for (int s = 1; s < H; s++) begin
         if (a_vld[s-1]) a_mode[s] <= a_mode[s-1];
      end
   end

   logic [NL:0]                        t_vld;
   logic [NL:0]                        t_mode;
   logic [NL:0][N_ARGS-1:0][RW-1:0]    lv;

   assign t_vld[0]  = a_vld[H-1];
   assign t_mode[0] = a_mode[H-1];

   for (genvar k = 0; k < N_ARGS; k++) begin : g_lv0
      assign lv[0][k] = RW'(roots[k]);
   end

   for (genvar l = 0; l < NL; l++) begin : g_lvl
      localparam int unsigned NC = level_count(N_ARGS, l);
      localparam int unsigned NN = level_count(N_ARGS, l + 1);
      logic v_r;
      logic m_r;
      logic is_max;

      assign is_max = (reduce_mode_t'(t_mode[l]) == MODE_MAX);

      always_ff @(posedge clk) begin
         if (!rst) v_r <= 1'b0;
         else      v_r <= t_vld[l];
      end

      always_ff @(posedge clk) begin
         if (t_vld[l]) m_r <= t_mode[l];
      end

      assign t_vld[l+1]  = v_r;
      assign t_mode[l+1] = m_r;

      for (genvar j = 0; j < N_ARGS; j++) begin : g_node
         if (j < NN) begin : g_reg
            logic [RW-1:0] a;
            logic [RW-1:0] b;
            logic [RW-1:0] d_r;

            assign a = lv[l][2*j];
            // A lone element pairs with zero, which is neutral for both sum and max.
            if (2*j + 1 < NC) begin : g_pair
               assign b = lv[l][2*j+1];
            end else begin : g_odd
               assign b = '0;
            end

            always_ff @(posedge clk) begin
               if (t_vld[l]) d_r <= is_max ? ((a > b) ? a : b) : RW'(a + b);
            end

            assign lv[l+1][j] = d_r;
         end else begin : g_zero
            assign lv[l+1][j] = '0;
         end
      end
   end

   logic [RW-1:0] res_reg;

   always_ff @(posedge clk) begin
      if (!rst) res_vld <= 1'b0;
      else      res_vld <= t_vld[NL];
   end

`ifdef ISQRT_REDUCE_PIPE_XMASK_EN
   always_ff @(posedge clk) begin
      if (t_vld[NL]) res_reg <= lv[NL][0];
   end

   assign res = res_vld ? res_reg : {RW{1'bx}};
`else
   // Cleared so res reads zero until the first result after reset.
   always_ff @(posedge clk) begin
      if (!rst)           res_reg <= '0;
      else if (t_vld[NL]) res_reg <= lv[NL][0];
   end

   assign res = res_reg;
`endif

   logic unused_bits;
   assign unused_bits = ^{root_vld, lv[NL]};

endmodule

// File: doc/isqrt_reduce_pipe.md
# isqrt_reduce_pipe

- Fully pipelined N-channel integer-square-root reducer.
- Each valid cycle it accepts N_ARGS unsigned operands, takes the floor square root of each, and reduces the roots by sum or by maximum, selected per transaction.
- It generalises the fixed three-operand sum-of-roots block in width, channel count and mode, and sits in the arithmetic pipelining library as a reusable datapath stage.
- Throughput is one transaction per clock with fixed latency. No backpressure.

## Interface
- `N_ARGS`, default 3: number of operand channels, range 1..16.
- `W`, default 32: operand width, even, range 4..64. Each root is `W/2` bits.
- `RW`, default `W/2 + $clog2(N_ARGS)`: result width; derived, not overridden.
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: reset, synchronous, active-low (asserted when 0).
- `arg_vld`  in  1: operand set valid this cycle.
- `mode`  in  1: `0` = sum of roots, `1` = max of roots. Sampled with `arg_vld`.
- `args`  in  `N_ARGS*W`: operands, channel k at bits `[k*W +: W]`.
- `res_vld`  out  1: result valid, one-cycle pulse per transaction.
- `res`  out  `RW`: reduced result.

## Operation
- **Stage group A: isqrt.**
  - One `isqrt_pipe` instance per channel, `W/2` registered stages.
  - Stage i resolves root bit `W/2-1-i` using the restoring method.
  - Root equals floor(sqrt(x)).
- **Stage group B: reduction tree.**
  - `$clog2(N_ARGS)` registered levels of pairwise sum or max.
  - An odd element passes through to the next level unchanged. Sum: passes as its value. Max: passes as its value, with zero as the pair partner.
  - `N_ARGS=1`: zero levels.
- **Stage group C: output register.** One output register.
- `mode` travels in a 1-bit shift register alongside the valid bits. Each tree level applies its own copy of `mode`, so mixed-mode streams are exact per transaction.
- **Power.** Each data register loads only when its stage valid bit is 1; otherwise it holds. Valid bits are the only state reset.
- **Widths.** Sums are zero-extended to `RW` and never overflow (max `N_ARGS*(2^(W/2)-1) < 2^RW`). Max results are zero-extended.
- No FSM: behaviour is a valid/mode shift chain plus enabled data registers.

## Timing
- Latency `L = W/2 + $clog2(N_ARGS) + 1` cycles from the `arg_vld` sample edge to `res_vld` high. Defaults give 19.
- Initiation interval 1. Back-to-back transactions produce back-to-back results, in order.
- **Reset values:**
  - `res_vld = 0`.
  - All internal valid bits = 0.
  - `res`: see Configuration. Data registers are not reset.
- **Reset mid-operation.**
  - The cycle after `rst` is sampled 0, `res_vld = 0`.
  - All in-flight transactions are discarded and never appear.
  - `arg_vld` is ignored while `rst = 0`.
  - The first transaction accepted after release appears exactly L cycles later.
- `arg_vld = 0` cycles create bubbles that propagate as `res_vld = 0` gaps of equal length.

## Configuration
- **`ISQRT_REDUCE_PIPE_XMASK_EN` defined:** `res` is driven to all-x whenever `res_vld = 0`. This exposes consumers that sample invalid data in simulation.
- **Not defined:**
  - `res` holds the last valid result.
  - `res` reads 0 after reset until the first result. This needs one reset-cleared output data register.
  - Synthesis builds use this setting.

## Structure
- Package `isqrt_reduce_pkg`:
  - Enum typedef `reduce_mode_t` (`MODE_SUM=0`, `MODE_MAX=1`).
  - Function `isqrt_reduce_latency(W, N_ARGS)` returning L, for benches and integrators.
- Sub-module `isqrt_pipe`, parameter `W`:
  - Ports: `clk`, `rst`, `x_vld`, `x`, `y_vld`, `y`.
  - Same reset convention; valid-gated data registers.
  - The top instantiates exactly `N_ARGS` of them.
- Reduction tree is generated in the top with a `generate` loop over levels.

## Test plan
1. Defaults, `mode=0`, args {16,25,36}, single pulse -> `res_vld` high exactly 19 cycles later for one cycle, `res=15`.
2. Same args, `mode=1`, followed next cycle by {15,0,1} with `mode=0` -> results 6 then 4 on consecutive cycles.
3. All args `0xFFFFFFFF`, `mode=0` -> `res=196605` (18 bits, no wrap). With `mode=1` -> `res=65535`.
4. Stream of 200 random transactions with random modes and random bubbles -> results match the reference model in order, with the same bubble pattern delayed by 19.
5. `rst=0` for one cycle while 10 transactions are in flight -> none emerge. A new transaction accepted after release appears after 19 cycles.
6. Parameter sweep (`N_ARGS`, `W`) over (1,4), (2,8), (5,16), (16,64): {max operand in every channel} -> sum = `N_ARGS*(2^(W/2)-1)`, latency = `isqrt_reduce_latency`.
